// File: rtl/rv_pkg.sv
// RV32I OP / OP-IMM opcode and funct7 constants, plus field encoders.
package rv_pkg;

  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  F7_BASE    = 7'h00;
  localparam logic [6:0]  F7_ALT     = 7'h20;
  localparam logic [6:0]  F7_MULDIV  = 7'h01;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

  function automatic logic [31:0] encode_i(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] funct3, input logic [4:0] rd);
    return {imm, rs1, funct3, rd, OPC_OP_IMM};
  endfunction

  function automatic logic [31:0] encode_r(input logic [6:0] funct7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] funct3,
                                           input logic [4:0] rd);
    return {funct7, rs2, rs1, funct3, rd, OPC_OP};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Show-ahead FIFO: the head entry sits in a register so it holds its last value once the FIFO drains.
module instr_fifo #(
  parameter int              DEPTH    = 4,
  parameter int              W        = 64,
  parameter logic [W-1:0]    RST_DATA = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_next;
  logic          do_push;
  logic          do_pop;

  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign do_push     = push && !full && !flush_i;
  assign do_pop      = pop && !empty && !flush_i;
  assign rd_ptr_next = rd_ptr + 1'b1;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= RST_DATA;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_next;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
      // Head refresh: next stored entry, or the incoming word when it becomes the head.
      if (do_pop && count > CNT_ONE)          rdata <= mem[rd_ptr_next];
      else if (do_push && (empty || do_pop))  rdata <= wdata;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes RV32I OP/OP-IMM requests, checks legality and queues {word, address} pairs.
// Optional macro NOP_ON_ILLEGAL_EN: illegal requests enqueue a NOP instead of being dropped.
module instr_encoder
  import rv_pkg::*;
#(
  parameter int                 DEPTH     = 4,
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_rtype_i,
  input  logic [2:0]                 req_funct3_i,
  input  logic [6:0]                 req_funct7_i,
  input  logic [4:0]                 req_rd_i,
  input  logic [4:0]                 req_rs1_i,
  input  logic [4:0]                 req_rs2_i,
  input  logic [11:0]                req_imm_i,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [31:0]                instr_o,
  output logic [ADDR_W-1:0]          instr_addr_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       illegal_o
);

  logic                legal;
  logic                accept;
  logic                push;
  logic [31:0]         enc_word;
  logic [31:0]         push_word;
  logic [ADDR_W-1:0]   next_addr;
  logic                full;
  logic                empty;

  always_comb begin
    legal = 1'b1;
    if (req_rtype_i) begin
      if (!(req_funct7_i inside {F7_BASE, F7_ALT, F7_MULDIV}))
        legal = 1'b0;
      else if (req_funct7_i == F7_ALT && !(req_funct3_i inside {3'b000, 3'b101}))
        legal = 1'b0;
    end else begin
      // Shift-immediate forms reuse imm[11:5] as a funct7 field.
      if (req_funct3_i == 3'b001 && req_imm_i[11:5] != 7'h00)
        legal = 1'b0;
      if (req_funct3_i == 3'b101 && !(req_imm_i[11:5] inside {F7_BASE, F7_ALT}))
        legal = 1'b0;
    end
  end

  assign enc_word = req_rtype_i
                  ? encode_r(req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i)
                  : encode_i(req_imm_i, req_rs1_i, req_funct3_i, req_rd_i);

  assign req_ready_o = !full && !flush_i;
  assign accept      = req_valid_i && req_ready_o;

`ifdef NOP_ON_ILLEGAL_EN
  assign push      = accept;
  assign push_word = legal ? enc_word : INSTR_NOP;
`else
  assign push      = accept && legal;
  assign push_word = enc_word;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      next_addr <= BASE_ADDR;
      illegal_o <= 1'b0;
    end else begin
      illegal_o <= accept && !legal;
      if (flush_i)   next_addr <= BASE_ADDR;
      else if (push) next_addr <= next_addr + ADDR_W'(4);
    end
  end

  instr_fifo #(
    .DEPTH    (DEPTH),
    .W        (32 + ADDR_W),
    .RST_DATA ({32'h0, BASE_ADDR})
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push    (push),
    .wdata   ({push_word, next_addr}),
    .pop     (instr_ready_i),
    .rdata   ({instr_o, instr_addr_o}),
    .count   (count_o),
    .full    (full),
    .empty   (empty)
  );

  assign instr_valid_o = !empty;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder; honours NOP_ON_ILLEGAL_EN when defined.
module tb_instr_encoder;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] a;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_rtype_i = 1'b0;
  logic [2:0]  req_funct3_i = '0;
  logic [6:0]  req_funct7_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic [4:0]  req_rs1_i = '0;
  logic [4:0]  req_rs2_i = '0;
  logic [11:0] req_imm_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b1;
  logic [31:0] instr_o;
  logic [31:0] instr_addr_o;
  logic [2:0]  count_o;
  logic        illegal_o;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  exp_t last = '0;
  exp_t popped;
  logic [31:0] exp_addr = 32'h0;
  bit   pending = 1'b0;
  bit   mon_legal;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_rtype_i   (req_rtype_i),
    .req_funct3_i  (req_funct3_i),
    .req_funct7_i  (req_funct7_i),
    .req_rd_i      (req_rd_i),
    .req_rs1_i     (req_rs1_i),
    .req_rs2_i     (req_rs2_i),
    .req_imm_i     (req_imm_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_addr_o  (instr_addr_o),
    .count_o       (count_o),
    .illegal_o     (illegal_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input bit rt, input bit [2:0] f3, input bit [6:0] f7,
                                             input bit [4:0] rd, input bit [4:0] rs1,
                                             input bit [4:0] rs2, input bit [11:0] imm);
    logic [31:0] w;
    if (rt) w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h33;
    else    w = (32'(imm) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h13;
    return w;
  endfunction

  function automatic bit model_legal(input bit rt, input bit [2:0] f3, input bit [6:0] f7,
                                     input bit [11:0] imm);
    bit [6:0] hi;
    hi = imm[11:5];
    if (rt) begin
      case (f7)
        7'h00, 7'h01: return 1'b1;
        7'h20:        return (f3 == 3'd0) || (f3 == 3'd5);
        default:      return 1'b0;
      endcase
    end
    case (f3)
      3'd1:    return hi == 7'h00;
      3'd5:    return (hi == 7'h00) || (hi == 7'h20);
      default: return 1'b1;
    endcase
  endfunction

  // Scoreboard: state seen at a falling edge reflects all previous rising edges.
  always @(negedge clk) begin
    if (!rst_i) begin
      q.delete();
      exp_addr = 32'h0;
      pending  = 1'b0;
      last     = '0;
    end else begin
      check("count", 64'(count_o), 64'(q.size()));
      check("valid", 64'(instr_valid_o), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("instr", 64'(instr_o), 64'(q[0].w));
        check("addr", 64'(instr_addr_o), 64'(q[0].a));
        last = q[0];
      end else begin
        check("hold_instr", 64'(instr_o), 64'(last.w));
        check("hold_addr", 64'(instr_addr_o), 64'(last.a));
      end
      check("ready", 64'(req_ready_o), 64'((q.size() < 4) && !flush_i));
      if (pending || illegal_o) check("illegal", 64'(illegal_o), 64'(pending));
      if (flush_i) begin
        q.delete();
        exp_addr = 32'h0;
        pending  = 1'b0;
      end else begin
        if (instr_valid_o && instr_ready_i && q.size() != 0) popped = q.pop_front();
        pending = 1'b0;
        if (req_valid_i && req_ready_o) begin
          mon_legal = model_legal(req_rtype_i, req_funct3_i, req_funct7_i, req_imm_i);
          pending = !mon_legal;
          if (mon_legal) begin
            q.push_back({model_word(req_rtype_i, req_funct3_i, req_funct7_i, req_rd_i,
                                    req_rs1_i, req_rs2_i, req_imm_i), exp_addr});
            exp_addr = exp_addr + 32'd4;
          end
`ifdef NOP_ON_ILLEGAL_EN
          else begin
            q.push_back({32'h0000_0013, exp_addr});
            exp_addr = exp_addr + 32'd4;
          end
`endif
        end
      end
    end
  end

  task automatic drive_req(input bit rt, input bit [2:0] f3, input bit [6:0] f7, input bit [4:0] rd,
                           input bit [4:0] rs1, input bit [4:0] rs2, input bit [11:0] imm);
    req_rtype_i  = rt;
    req_funct3_i = f3;
    req_funct7_i = f7;
    req_rd_i     = rd;
    req_rs1_i    = rs1;
    req_rs2_i    = rs2;
    req_imm_i    = imm;
    req_valid_i  = 1'b1;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        return;
      end
    end
    check("accept_timeout", 64'd0, 64'd1);
    req_valid_i = 1'b0;
  endtask

  task automatic send(input bit rt, input bit [2:0] f3, input bit [6:0] f7, input bit [4:0] rd,
                      input bit [4:0] rs1, input bit [4:0] rs2, input bit [11:0] imm);
    drive_req(rt, f3, f7, rd, rs1, rs2, imm);
    wait_accept();
  endtask

  task automatic drain();
    instr_ready_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted between edges, checked before any clock edge.
    #2 rst_i = 1'b0;
    #1;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_valid", 64'(instr_valid_o), 64'd0);
    check("rst_instr", 64'(instr_o), 64'd0);
    check("rst_addr", 64'(instr_addr_o), 64'd0);
    check("rst_illegal", 64'(illegal_o), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst_i = 1'b1;

    // addi x1,x2,5 then sub x3,x1,x2
    send(1'b0, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 12'd5);
    @(negedge clk);
    check("t1_valid", 64'(instr_valid_o), 64'd1);
    check("t1_instr", 64'(instr_o), 64'h0051_0093);
    check("t1_addr", 64'(instr_addr_o), 64'h0);
    @(posedge clk); #1;
    send(1'b1, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 12'd0);
    @(negedge clk);
    check("t2_instr", 64'(instr_o), 64'h4020_81B3);
    check("t2_addr", 64'(instr_addr_o), 64'h4);
    @(posedge clk); #1;
    drain();

    flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;

    // Fill to DEPTH with the sink stalled, then hold a fifth request.
    instr_ready_i = 1'b0;
    send(1'b0, 3'd7, 7'h00, 5'd4, 5'd5, 5'd0, 12'hABC);
    send(1'b1, 3'd4, 7'h01, 5'd6, 5'd7, 5'd8, 12'd0);
    send(1'b0, 3'd5, 7'h00, 5'd9, 5'd10, 5'd0, 12'h405);
    send(1'b1, 3'd5, 7'h20, 5'd11, 5'd12, 5'd13, 12'd0);
    drive_req(1'b0, 3'd1, 7'h00, 5'd14, 5'd15, 5'd0, 12'h01F);
    repeat (3) begin
      @(negedge clk);
      check("t3_full_ready", 64'(req_ready_o), 64'd0);
      check("t3_full_count", 64'(count_o), 64'd4);
    end
    @(posedge clk); #1 instr_ready_i = 1'b1;
    wait_accept();
    drain();
    check("t3_last_addr", 64'(instr_addr_o), 64'h10);

    // Illegal R-type funct7=0x20 with funct3=001
    send(1'b1, 3'd1, 7'h20, 5'd1, 5'd2, 5'd3, 12'd0);
    @(negedge clk);
    check("t4_illegal", 64'(illegal_o), 64'd1);
`ifdef NOP_ON_ILLEGAL_EN
    check("t4_nop", 64'(instr_o), 64'h0000_0013);
    check("t4_nop_addr", 64'(instr_addr_o), 64'h14);
`else
    check("t4_dropped", 64'(instr_valid_o), 64'd0);
    check("t4_addr_held", 64'(instr_addr_o), 64'h10);
`endif
    @(negedge clk);
    check("t4_pulse_end", 64'(illegal_o), 64'd0);
    @(posedge clk); #1;
    send(1'b0, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 12'h020);
    send(1'b0, 3'd5, 7'h00, 5'd2, 5'd2, 5'd0, 12'h7FF);
    send(1'b1, 3'd0, 7'h7F, 5'd3, 5'd3, 5'd3, 12'd0);
    send(1'b1, 3'd7, 7'h00, 5'd4, 5'd5, 5'd6, 12'd0);
    send(1'b0, 3'd5, 7'h00, 5'd7, 5'd8, 5'd0, 12'h01F);
    drain();

    // Flush together with a valid request.
    instr_ready_i = 1'b0;
    send(1'b0, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 12'd1);
    send(1'b0, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 12'd2);
    send(1'b0, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 12'd3);
    flush_i = 1'b1;
    drive_req(1'b0, 3'd6, 7'h00, 5'd20, 5'd21, 5'd0, 12'h0F0);
    @(negedge clk);
    check("t5_ready_flush", 64'(req_ready_o), 64'd0);
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    check("t5_count", 64'(count_o), 64'd0);
    @(posedge clk); #1;
    wait_accept();
    instr_ready_i = 1'b1;
    @(negedge clk);
    check("t5_addr", 64'(instr_addr_o), 64'h0);
    check("t5_instr", 64'(instr_o), 64'(model_word(1'b0, 3'd6, 7'h00, 5'd20, 5'd21, 5'd0, 12'h0F0)));
    drain();

    // Asynchronous reset with two entries queued.
    instr_ready_i = 1'b0;
    send(1'b1, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 12'd0);
    send(1'b1, 3'd0, 7'h00, 5'd4, 5'd5, 5'd6, 12'd0);
    @(negedge clk);
    check("t6_pre_count", 64'(count_o), 64'd2);
    @(posedge clk); #3 rst_i = 1'b0;
    #1;
    check("t6_count", 64'(count_o), 64'd0);
    check("t6_valid", 64'(instr_valid_o), 64'd0);
    check("t6_instr", 64'(instr_o), 64'd0);
    check("t6_addr", 64'(instr_addr_o), 64'd0);
    @(posedge clk); #1 rst_i = 1'b1;
    instr_ready_i = 1'b1;
    send(1'b0, 3'd4, 7'h00, 5'd9, 5'd8, 5'd0, 12'h123);
    @(negedge clk);
    check("t6_first_addr", 64'(instr_addr_o), 64'h0);
    check("t6_first_valid", 64'(instr_valid_o), 64'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
